// File: rtl/pipe_adder_pkg.sv
// Shared constants, op encoding and saturation helper for the pipelined adder.
package pipe_adder_pkg;

   localparam int unsigned DefWidth  = 32;
   localparam int unsigned DefStages = 4;
   localparam int unsigned MaxWidth  = 256;

   typedef enum logic {
      OpAdd = 1'b0,
      OpSub = 1'b1
   } op_e;

   // Two's-complement limit for a width-bit result: 0x80..0 when neg, else 0x7F..F.
   function automatic logic [MaxWidth-1:0] sat_limit(input int unsigned width, input logic neg);
      logic [MaxWidth-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MaxWidth; i++) begin
         if (i + 1 < width) begin
            v[i] = ~neg;
         end else if (i + 1 == width) begin
            v[i] = neg;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// CH-bit ripple slice: sum, carry out, and the carry entering the slice MSB.
module adder_slice #(
   parameter int unsigned CH = 8
) (
   input  logic [CH-1:0] a,
   input  logic [CH-1:0] b,
   input  logic          ci,
   output logic [CH-1:0] s,
   output logic          co,
   output logic          c_msb
);

   logic [CH:0] c;

   always_comb begin
      c[0] = ci;
      for (int unsigned i = 0; i < CH; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[CH];
   assign c_msb = c[CH-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one CH-bit slice per stage, valid/ready with global stall.
// Optional macro PIPE_ADDER_SAT_EN saturates sum on signed overflow.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned STAGES = DefStages
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CH   = WIDTH / STAGES;
   localparam int unsigned Last = STAGES - 1;

   logic             adv;
   logic             vld_q  [STAGES];
   logic             sub_q  [STAGES];
   logic             c_q    [STAGES];
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] psum_q [STAGES];
   logic [WIDTH-1:0] psum_d [STAGES];

   logic [CH-1:0]    slice_s    [STAGES];
   logic             slice_co   [STAGES];
   logic             slice_cmsb [STAGES];

   logic [WIDTH-1:0] res_wrap;
   logic [WIDTH-1:0] res;
   logic             res_ovf;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv || rst;

   // Stage k adds its own slice of the operands held in stage register k.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_slice #(
         .CH(CH)
      ) u_slice (
         .a    (a_q[k][k*CH +: CH]),
         .b    (b_q[k][k*CH +: CH]),
         .ci   (c_q[k]),
         .s    (slice_s[k]),
         .co   (slice_co[k]),
         .c_msb(slice_cmsb[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         psum_d[k] = '0;
      end
      for (int k = 1; k < STAGES; k++) begin
         psum_d[k] = psum_q[k-1];
         psum_d[k][(k-1)*CH +: CH] = slice_s[k-1];
      end
   end

   always_comb begin
      res_wrap = psum_q[Last];
      res_wrap[Last*CH +: CH] = slice_s[Last];
      res_ovf = slice_cmsb[Last] ^ slice_co[Last];
   end

`ifdef PIPE_ADDER_SAT_EN
   logic [MaxWidth-1:0] sat_full;

   // On overflow the carry out gives the direction: set means negative overflow.
   always_comb begin
      sat_full = sat_limit(WIDTH, slice_co[Last]);
      res      = res_ovf ? sat_full[WIDTH-1:0] : res_wrap;
   end
`else
   assign res = res_wrap;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         // Subtract is folded in here as a + ~b + 1.
         vld_q[0] <= in_valid;
         a_q[0]   <= a;
         b_q[0]   <= (sub == OpSub) ? ~b : b;
         c_q[0]   <= (sub == OpSub) ? 1'b1 : cin;
         sub_q[0] <= sub;
         for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            a_q[k]   <= a_q[k-1];
            b_q[k]   <= b_q[k-1];
            c_q[k]   <= slice_co[k-1];
            sub_q[k] <= sub_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            psum_q[k] <= psum_d[k];
         end
         out_valid <= vld_q[Last];
         sum       <= res;
         cout      <= slice_co[Last];
         ovf       <= res_ovf;
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4): directed vectors, backpressure, reset.
module tb_pipe_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   pipe_adder #(
      .WIDTH (32),
      .STAGES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          bp_en = 1'b0;
   bit          hold_pend = 1'b0;
   logic [31:0] hold_s;
   logic        hold_c;
   logic        hold_o;

   // Hand-computed wrapped results for the backpressure stream.
   logic [31:0] bp_a [16] = '{32'h00000001, 32'h00000010, 32'h00000003, 32'h12345678,
                              32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                              32'h00FF00FF, 32'h0000FFFF, 32'h40000000, 32'h7FFFFFFF,
                              32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000100, 32'hFFFF0000};
   logic [31:0] bp_b [16] = '{32'h00000002, 32'h00000003, 32'h00000005, 32'h11111111,
                              32'h11111111, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                              32'hFF00FF00, 32'h0000FFFF, 32'h40000000, 32'hFFFFFFFF,
                              32'h55555555, 32'h55555555, 32'h00000001, 32'h0000FFFF};
   logic        bp_ci [16] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
   logic        bp_sb [16] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
   logic [31:0] bp_s [16] = '{32'h00000003, 32'h0000000D, 32'hFFFFFFFE, 32'h23456789,
                              32'h2345678A, 32'hFFFFFFFE, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'h0001FFFE, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFF, 32'h00000000, 32'h000000FF, 32'hFFFE0001};
   logic        bp_co [16] = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
   logic        bp_ov [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // With saturation, overflow clamps toward the sign of operand a.
   function automatic logic [31:0] exp_sum(input logic [31:0] wrap, input logic [31:0] ta,
                                           input logic o);
`ifdef PIPE_ADDER_SAT_EN
      if (o) return ta[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
      return wrap;
   endfunction

   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic ts, input logic [31:0] ws, input logic ec, input logic eo,
                       input bit lat);
      exp_t e;
      int   n;
      a        = ta;
      b        = tb;
      cin      = tc;
      sub      = ts;
      in_valid = 1'b1;
      n        = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
      end else begin
         e.s   = exp_sum(ws, ta, eo);
         e.c   = ec;
         e.o   = eo;
         e.acc = cyc + 1;
         e.lat = lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_pending", q.size(), 0);
   endtask

   // Consumer: random backpressure while bp_en is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops and compares each result as it leaves.
   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
         if (hold_pend) begin
            check("held_valid", out_valid, 1);
            check("held_sum", sum, hold_s);
            check("held_cout", cout, hold_c);
            check("held_ovf", ovf, hold_o);
         end
         hold_pend = out_valid && !out_ready;
         hold_s    = sum;
         hold_c    = cout;
         hold_o    = ovf;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_result", out_valid, 0);
            end else begin
               mon_e = q.pop_front();
               check("sum", sum, mon_e.s);
               check("cout", cout, mon_e.c);
               check("ovf", ovf, mon_e.o);
               if (mon_e.lat) check("latency", cyc - mon_e.acc, 4);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      @(posedge clk);
      #1;

      // Directed, no backpressure: exact latency checked.
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1);
      send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
      drain(50);

      // Backpressure stream with random input bubbles.
      bp_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(bp_a[i], bp_b[i], bp_ci[i], bp_sb[i], bp_s[i], bp_co[i], bp_ov[i], 1'b0);
      end
      bp_en = 1'b0;
      drain(300);
      @(posedge clk);
      #1;

      // Reset with three results in flight: none may emerge.
      send(32'h00000011, 32'h00000022, 1'b0, 1'b0, 32'h00000033, 1'b0, 1'b0, 1'b1);
      send(32'h00000100, 32'h00000200, 1'b0, 1'b0, 32'h00000300, 1'b0, 1'b0, 1'b1);
      send(32'h00001000, 32'h00000001, 1'b0, 1'b1, 32'h00000FFF, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send(32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b1);
      drain(50);
      repeat (10) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, with 1 <= STAGES <= WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  raw carry out of the MSB (1 = no borrow when sub=1).
REQ-014 ovf  output  1  signed (two's-complement) overflow of the exact operation.

Function
REQ-015 SHALL compute a + b + cin when sub=0, and a + ~b + 1 when sub=1.
REQ-016 SHALL split the operation into STAGES slices of CH = WIDTH/STAGES bits; stage k adds bits [k*CH +: CH], registers the slice carry, and passes it to stage k+1 one cycle later.
REQ-017 Each stage SHALL hold a valid bit, its partial sum, the not-yet-added upper operand bits, and the sub flag.
REQ-018 Stage global advance SHALL be adv = !out_valid || out_ready; when adv=0 every stage SHALL hold its contents.
REQ-019 in_ready SHALL equal adv combinationally; a transfer occurs when in_valid && in_ready.
REQ-020 A result SHALL appear on out_valid exactly STAGES adv-cycles after its accept; with no stalls, accept at edge N gives out_valid at edge N+STAGES.
REQ-021 One transfer per cycle SHALL be sustained; bubbles (in_valid=0) SHALL propagate as invalid stages, not collapse.
REQ-022 Results SHALL leave in acceptance order, never dropped or duplicated.
REQ-023 sum, cout and ovf SHALL stay stable while out_valid=1 && out_ready=0.
REQ-024 ovf SHALL be computed as the MSB carry-in XOR the MSB carry-out of the final stage.
REQ-025 Simultaneous output pop and input accept in one cycle SHALL be legal and lossless.

Reset
REQ-026 While rst=1 at a clock edge, all stage valid bits, out_valid, sum, cout and ovf SHALL clear to 0.
REQ-027 During reset and on the first cycle after it, in_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results with no later out_valid for them.

Configuration
REQ-029 Macro PIPE_ADDER_SAT_EN: when defined, if ovf=1 then sum SHALL saturate to 0x7F..F (positive overflow) or 0x80..0 (negative overflow); cout and ovf are unchanged.
REQ-030 Without PIPE_ADDER_SAT_EN, sum SHALL be the wrapped WIDTH-bit result; ovf is still reported.

Structure
REQ-031 The shared package pipe_adder_pkg SHALL hold the default WIDTH/STAGES constants, the add/sub op encoding, and the saturation-limit function.
REQ-032 A single sub-module adder_slice (CH-bit combinational add with carry-in/out and MSB carry-in tap) SHALL be instantiated once per stage via generate.

Verification (WIDTH=32, STAGES=4)
REQ-033 Reset: rst=1 for 2 cycles -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
REQ-034 Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-035 Slice boundary: a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0, ovf=0.
REQ-036 Subtract overflow: a=0x80000000, b=0x00000001, sub=1 -> cout=1, ovf=1; sum=0x7FFFFFFF without the macro, 0x80000000 with PIPE_ADDER_SAT_EN.
REQ-037 Backpressure stream: 16 random transactions, in_valid and out_ready randomly toggled -> 16 results in order matching the reference model, outputs held while stalled, in_ready=0 exactly when out_valid=1 && out_ready=0.
REQ-038 Reset mid-flight: 3 transactions in flight, rst=1 for 1 cycle -> none emerge; the next accepted a=5, b=3 yields sum=8 after 4 cycles.
